// File: rtl/led_arbiter.sv
// led_arbiter: round-robin LED bank sharing between puzzle modules; strike flash built only with LED_STRIKE_FLASH_EN
module led_arbiter #(
  parameter int N_REQ       = 3,
  parameter int DWELL       = 4,
  parameter int FLASH_TICKS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*18-1:0]  red_pat,
  input  logic [N_REQ*8-1:0]   grn_pat,
  input  logic [N_REQ-1:0]     solved,
  input  logic                 strike,
  output logic [N_REQ-1:0]     gnt,
  output logic [17:0]          ledR,
  output logic [7:0]           ledG,
  output logic                 busy
);
  localparam int PW = (N_REQ > 2) ? 2 : 1;
  typedef enum logic [1:0] {
    IDLE,
`ifdef LED_STRIKE_FLASH_EN
    FLASH,
`endif
    SHOW
  } state_t;
  state_t stateQ, stateD;
  logic [N_REQ-1:0] eff, gntD;
  logic [PW-1:0] ptrQ, ptrD, selQ, selD, win;
  logic [3:0] dwellQ, dwellD;
  logic [17:0] ledRD;
  logic [7:0] ledGD;
  logic anyEff, doGrant;
`ifdef LED_STRIKE_FLASH_EN
  logic [3:0] cntQ, cntD;
  logic phaseQ, phaseD;
`else
  logic unused;
  assign unused = strike ^ (FLASH_TICKS > 0);
`endif
  assign eff = req & ~solved;
  assign anyEff = |eff;
  assign busy = stateQ != IDLE;
  // first effective requester at or after ptr, wrapping
  always_comb begin
    win = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (eff[(int'(ptrQ) + k) % N_REQ]) win = PW'((int'(ptrQ) + k) % N_REQ);
  end
  // next state, grant bookkeeping and the LED values to register
  always_comb begin
    stateD = stateQ;
    selD = selQ;
    ptrD = ptrQ;
    dwellD = dwellQ;
    doGrant = 1'b0;
    case (stateQ)
      IDLE: doGrant = anyEff;
      SHOW: begin
        if (!eff[selQ] || (tick && dwellQ == 4'(DWELL - 1))) begin
          doGrant = anyEff;
          stateD = anyEff ? SHOW : IDLE;
        end else begin
          dwellD = dwellQ + 4'(tick);
        end
      end
      default: ;
    endcase
    if (doGrant) begin
      stateD = SHOW;
      selD = win;
      ptrD = PW'((int'(win) + 1) % N_REQ);
      dwellD = '0;
    end
`ifdef LED_STRIKE_FLASH_EN
    cntD = cntQ;
    phaseD = phaseQ;
    if (stateQ == FLASH && tick) begin
      if (cntQ == 4'(FLASH_TICKS - 1)) begin
        stateD = IDLE;
      end else begin
        cntD = cntQ + 4'd1;
        phaseD = ~phaseQ;
      end
    end
    if (strike) begin
      stateD = FLASH;
      selD = selQ;
      ptrD = ptrQ;
      dwellD = dwellQ;
      cntD = '0;
      phaseD = 1'b1;
    end
`endif
    gntD = (stateD == SHOW) ? (N_REQ'(1) << selD) : '0;
    ledRD = (stateD == SHOW) ? red_pat[int'(selD)*18 +: 18] : '0;
`ifdef LED_STRIKE_FLASH_EN
    if (stateD == FLASH) ledRD = {18{phaseD}};
`endif
    ledGD = ((stateD == SHOW) ? grn_pat[int'(selD)*8 +: 8] : 8'h00) | 8'(solved);
  end
  // state and registered outputs, cleared asynchronously by reset low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
      ptrQ <= '0;
      selQ <= '0;
      dwellQ <= '0;
      gnt <= '0;
      ledR <= '0;
      ledG <= '0;
    end else begin
      stateQ <= stateD;
      ptrQ <= ptrD;
      selQ <= selD;
      dwellQ <= dwellD;
      gnt <= gntD;
      ledR <= ledRD;
      ledG <= ledGD;
    end
  end
`ifdef LED_STRIKE_FLASH_EN
  // flash tick counter and blink phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cntQ <= '0;
      phaseQ <= 1'b0;
    end else begin
      cntQ <= cntD;
      phaseQ <= phaseD;
    end
  end
`endif
endmodule

// File: tb/tb_led_arbiter.sv
// tb_led_arbiter: scoreboard bench for led_arbiter (N_REQ=3, DWELL=4, FLASH_TICKS=6)
module tb_led_arbiter;
  logic clk = 1'b0, reset = 1'b0, tick = 1'b0, strike = 1'b0;
  logic [2:0] req = 3'b000, solved = 3'b000, gnt;
  logic [17:0] ledR;
  logic [7:0] ledG;
  logic busy;
  logic [17:0] red [3] = '{18'h0AAA1, 18'h15552, 18'h3C3C3};
  logic [7:0] grn [3] = '{8'hA0, 8'h50, 8'hC8};
  logic [53:0] redPat;
  logic [23:0] grnPat;
  logic [29:0] obs;
  logic [29:0] expQ [$];
  int tests = 0, fails = 0, cur = 0, tk = 0;
  assign redPat = {red[2], red[1], red[0]};
  assign grnPat = {grn[2], grn[1], grn[0]};
  assign obs = {busy, gnt, ledR, ledG};
  led_arbiter #(.N_REQ(3), .DWELL(4), .FLASH_TICKS(6)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .red_pat(redPat),
    .grn_pat(grnPat), .solved(solved), .strike(strike), .gnt(gnt),
    .ledR(ledR), .ledG(ledG), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [29:0] showE(int i);
    return {1'b1, 3'(1 << i), red[i], grn[i] | {5'b0, solved}};
  endfunction
  function automatic logic [29:0] idleE();
    return {1'b0, 3'b000, 18'h0, 5'b0, solved};
  endfunction
  function automatic logic [29:0] flashE(logic ph);
    return {1'b1, 3'b000, {18{ph}}, 5'b0, solved};
  endfunction
  task automatic check(string tag, logic [29:0] got, logic [29:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(string tag, logic t, logic s, logic [29:0] e);
    tick = t;
    strike = s;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    tick = 1'b0;
    strike = 1'b0;
    check(tag, obs, expQ.pop_front());
  endtask
  task automatic rotStep(string tag, logic t, logic s);
    if (t && tk == 3) begin
      cur = (cur + 1) % 3;
      tk = 0;
    end else begin
      tk += int'(t);
    end
    step(tag, t, s, showE(cur));
  endtask
  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_async", obs, 30'h0);
    @(posedge clk);
    #1;
    check("rst_hold", obs, 30'h0);
    reset = 1'b1;
  endtask
  initial begin
    req = 3'b111;
    doReset();
    step("grant0", 0, 0, showE(0));
    cur = 0;
    tk = 0;
    for (int c = 0; c < 40; c++) rotStep("rotate", c % 2 == 1, 0);
    red[cur] = red[cur] ^ 18'h3FFFF;
    rotStep("track", 0, 0);
    doReset();
    req = 3'b010;
    step("first_grant", 0, 0, showE(1));
    req = 3'b111;
    step("dwell_hold", 1, 0, showE(1));
    req = 3'b101;
    step("early_release", 0, 0, showE(2));
    doReset();
    req = 3'b010;
    step("sole_grant", 0, 0, showE(1));
    for (int c = 0; c < 20; c++) step("sole_regrant", 1, 0, showE(1));
    doReset();
    req = 3'b001;
    solved = 3'b001;
    for (int c = 0; c < 3; c++) step("solved_mask", 1, 0, idleE());
    req = 3'b011;
    step("solved_or", 0, 0, showE(1));
    solved = 3'b000;
    doReset();
    req = 3'b111;
    step("s_grant0", 0, 0, showE(0));
    cur = 0;
    tk = 0;
`ifdef LED_STRIKE_FLASH_EN
    step("strike", 0, 1, flashE(1'b1));
    for (int i = 1; i < 6; i++) step("flash", 1, 0, flashE(i % 2 == 0));
    step("flash_end", 1, 0, idleE());
    step("post_flash", 0, 0, showE(1));
    step("strike2", 0, 1, flashE(1'b1));
    for (int i = 1; i < 3; i++) step("flash2", 1, 0, flashE(i % 2 == 0));
    step("restrike", 1, 1, flashE(1'b1));
    for (int i = 1; i < 6; i++) step("flash3", 1, 0, flashE(i % 2 == 0));
    step("flash3_end", 1, 0, idleE());
    step("post_flash2", 0, 0, showE(2));
`else
    for (int i = 0; i < 12; i++) rotStep("no_strike", i % 2 == 1, i == 2 || i == 7);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_arbiter.md
# led_arbiter

Time-shares the DE2 board LED bank (ledR[17:0], ledG[7:0]) between the bomb's puzzle modules. Each module raises a request with its own red/green pattern. The arbiter grants the LEDs round-robin for a bounded dwell time measured in slow `tick` pulses. A strike pulse overrides everything with a full-bank red flash. It sits between the puzzle modules and the top-level LED pins.

## Interface
Parameters:
- N_REQ, 3, number of requesters (legal 2..4)
- DWELL, 4, ticks a grant is held before rotation (legal 1..15)
- FLASH_TICKS, 6, tick-length of the strike flash (legal 2..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- tick  in  1  one-clk-wide slow time-base enable
- req  in  N_REQ  level request per module
- red_pat  in  N_REQ*18  requester i red pattern at [18*i+17:18*i]
- grn_pat  in  N_REQ*8  requester i green pattern at [8*i+7:8*i]
- solved  in  N_REQ  level; module i defused
- strike  in  1  one-clk pulse; wrong action taken
- gnt  out  N_REQ  one-hot grant, or all zero
- ledR  out  18  red LED drive
- ledG  out  8  green LED drive
- busy  out  1  1 when state is not IDLE

## Operation
- States: IDLE, SHOW, FLASH (FLASH exists only with LED_STRIKE_FLASH_EN).
- Effective request: eff[i] = req[i] & ~solved[i]. Solved modules never win.
- Round-robin pointer `ptr`: search starts at ptr and wraps modulo N_REQ; first eff bit wins. On every grant, ptr = winner+1 mod N_REQ.
- IDLE -> SHOW when any eff is set. Load gnt with the winner and clear the dwell counter.
- SHOW: dwell counter increments on each tick.
- SHOW release on either condition:
  - eff[granted] drops, or
  - tick arrives with dwell counter == DWELL-1.
- On release, if any eff is set (including the same requester as sole requester), grant the next winner in the same edge with no IDLE gap and restart dwell. Otherwise go to IDLE.
- Outputs:
  - ledR = red_pat[granted] in SHOW; 0 in IDLE.
  - ledG = grn_pat[granted] in SHOW, 0 otherwise; then OR solved into ledG[N_REQ-1:0] in every state.
- strike, sampled in any state -> FLASH:
  - gnt = 0; flash tick counter cleared; flash phase = 1.
  - ledR = {18{phase}}; phase toggles on each tick.
  - Exit to IDLE when tick arrives with counter == FLASH_TICKS-1. ptr is unchanged.
  - strike during FLASH restarts the counter and sets phase = 1.
- Simultaneous events in one cycle:
  - strike beats any release or grant.
  - Release beats a dwell tick.

## Timing
- All outputs are registered.
- Reset values: gnt=0, ledR=0, ledG=0, busy=0, ptr=0, state IDLE, counters 0.
- Grant latency: eff high at rising edge n -> gnt/ledR/ledG valid after edge n.
- Pattern tracking: red_pat/grn_pat changes while granted appear on ledR/ledG one edge later.
- Release: eff[granted] low at edge n -> gnt changes at edge n.
- Reset mid-operation (reset=0) forces all outputs to reset values asynchronously. On reset release, the first edge behaves as IDLE.

## Configuration
- LED_STRIKE_FLASH_EN defined: FLASH state and strike handling are present as described.
- LED_STRIKE_FLASH_EN not defined:
  - strike is ignored, FLASH_TICKS is unused, no FLASH logic is built.
  - busy = 1 only in SHOW.

## Test plan
- Reset/idle: hold reset=0 with req=3'b111 -> gnt=0, ledR=0, ledG=0. Release reset, then one edge -> gnt=3'b001, ledR=red_pat[0].
- Rotation: req=3'b111 held, DWELL=4 -> grant sequence 001, 010, 100, 001, each lasting exactly 4 ticks, with no IDLE cycle between grants.
- Early release and solved masking:
  - Drop req[1] mid-dwell -> gnt moves to 100 at that edge.
  - solved=3'b001 with req=3'b001 -> gnt stays 0 and ledG[0]=1.
- Sole requester: req=3'b010 only -> re-granted 010 after each dwell expiry; busy stays 1.
- Strike (macro on), strike pulse in SHOW:
  - gnt=0; ledR alternates 18'h3FFFF/0 per tick, starting 3FFFF.
  - IDLE after 6 ticks.
  - Second strike at tick 3 extends the flash to 3+6 ticks.
- Macro off: same strike stimulus -> no change to gnt or ledR.
